// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types and parameter helpers for the APB wait-state memory slave.
package apb_slv_pkg;

    // Slave phase tracking. The register follows the bus one phase behind:
    // SETUP is entered on the edge that closes the bus setup cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Number of byte-address bits that select a lane inside one data word.
    function automatic int calc_lsb(input int width);
        return (width / 8 > 1) ? $clog2(width / 8) : 0;
    endfunction

    // Number of byte-lane strobes for a given data width.
    function automatic int strb_w(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/apb_slv_bytemem.sv
// apb_slv_bytemem: DEPTH x WIDTH storage with per-byte write enables,
// synchronous write and asynchronous (combinational) read. Contents are never reset.
module apb_slv_bytemem
    import apb_slv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 128,
    parameter int AW     = 7
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [strb_w(WIDTH)-1:0] strb,
    input  logic [AW-1:0]            addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    localparam int STRB_W = strb_w(WIDTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Byte-lane masked write: only lanes with their strobe set take new data.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (strb[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/apb_wait_mem_slave.sv
// apb_wait_mem_slave: parametrised APB memory slave with run-time programmable
// wait states. Holds the phase FSM, the wait counter and the address decode;
// storage lives in apb_slv_bytemem.
// Optional feature: define APB_SLV_ERR_EN to signal Pslverr on out-of-range
// accesses. Without it Pslverr is tied low; out-of-range writes are dropped and
// out-of-range reads return zero in both builds.
module apb_wait_mem_slave
    import apb_slv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 10,
    parameter int DEPTH     = 128,
    parameter int WAIT_W    = 4
) (
    input  logic                     Pclk,
    input  logic                     Preset,
    input  logic                     Psel,
    input  logic                     Penable,
    input  logic                     Pwrite,
    input  logic [strb_w(WIDTH)-1:0] Pstrb,
    input  logic [ADD_WIDTH-1:0]     Paddr,
    input  logic [WIDTH-1:0]         Pwdata,
    input  logic [WAIT_W-1:0]        Wait_cfg,
    output logic [WIDTH-1:0]         Prdata,
    output logic                     Pready,
    output logic                     Pslverr
);

    localparam int LSB    = calc_lsb(WIDTH);
    localparam int IDX_W  = ADD_WIDTH - LSB;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**IDX_W is still representable.
    localparam logic [IDX_W:0] DEPTH_EXT = (IDX_W + 1)'(DEPTH);

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   cnt;
    logic [IDX_W-1:0]    index;
    logic                in_range;
    logic                pready;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_addr;
    logic [WIDTH-1:0]    mem_rdata;
    logic                unused_addr;

    // Byte offset bits inside a word carry no meaning for a word-wide slave.
    assign unused_addr = ^Paddr;

    assign index    = Paddr[ADD_WIDTH-1:LSB];
    assign in_range = {1'b0, index} < DEPTH_EXT;
    assign mem_addr = index[MEM_AW-1:0];

    assign pready = (state == ACCESS) && Psel && Penable && (cnt == '0);
    assign mem_we = pready && Pwrite && in_range;

    // Phase state register; an asynchronous reset aborts any transfer in flight.
    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next phase: Penable in IDLE is ignored, and losing Psel in ACCESS abandons the transfer.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (Psel && !Penable) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    next_state = (Psel && !Penable) ? SETUP : IDLE;
                end else if (!Psel) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Wait counter: captures Wait_cfg while in SETUP, then counts down to zero and holds.
    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= Wait_cfg;
        end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    apb_slv_bytemem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (MEM_AW)
    ) u_mem (
        .clk   (Pclk),
        .we    (mem_we),
        .strb  (Pstrb),
        .addr  (mem_addr),
        .wdata (Pwdata),
        .rdata (mem_rdata)
    );

    assign Pready = pready;
    assign Prdata = (pready && !Pwrite && in_range) ? mem_rdata : '0;

`ifdef APB_SLV_ERR_EN
    assign Pslverr = pready && !in_range;
`else
    assign Pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_wait_mem_slave.sv
// tb_apb_wait_mem_slave: directed self-checking bench for apb_wait_mem_slave
// (WIDTH=32, ADD_WIDTH=10, DEPTH=128, WAIT_W=4). Expectations follow APB_SLV_ERR_EN.
module tb_apb_wait_mem_slave;

`ifdef APB_SLV_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        Pclk;
    logic        Preset;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [3:0]  Pstrb;
    logic [9:0]  Paddr;
    logic [31:0] Pwdata;
    logic [3:0]  Wait_cfg;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    int tests;
    int fails;

    apb_wait_mem_slave #(
        .WIDTH     (32),
        .ADD_WIDTH (10),
        .DEPTH     (128),
        .WAIT_W    (4)
    ) dut (
        .Pclk     (Pclk),
        .Preset   (Preset),
        .Psel     (Psel),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Pstrb    (Pstrb),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Wait_cfg (Wait_cfg),
        .Prdata   (Prdata),
        .Pready   (Pready),
        .Pslverr  (Pslverr)
    );

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;

    // Hard stop in case a bus wait goes wrong in a way the bounded loops miss.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One complete master transfer: setup cycle, then enable held until Pready.
    // The slave spends the first enable cycle in SETUP, so waits = Wait_cfg + 1.
    // Returns during the Pready cycle with the bus still driven.
    task automatic xfer(input logic w, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] wc,
                        output logic [31:0] rd, output logic err, output int waits);
        @(posedge Pclk); #1;
        Psel = 1'b1; Penable = 1'b0; Pwrite = w; Paddr = a;
        Pwdata = d; Pstrb = s; Wait_cfg = wc;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        waits = 0;
        while (!Pready && waits < 64) begin
            waits++;
            @(posedge Pclk); #1;
        end
        rd  = Prdata;
        err = Pslverr;
    endtask

    task automatic bus_idle();
        @(posedge Pclk); #1;
        Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    endtask

    task automatic test_reset();
        Preset = 1'b1; Psel = 1'b1; Penable = 1'b1; Pwrite = 1'b0;
        Paddr = '0; Pwdata = '0; Pstrb = '0; Wait_cfg = '0;
        @(posedge Pclk); #1;
        tests++;
        if (Pready !== 1'b0) begin fails++; $display("[TB] FAIL reset_pready got %b want 0", Pready); end
        tests++;
        if (Prdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_prdata got %h want 0", Prdata); end
        tests++;
        if (Pslverr !== 1'b0) begin fails++; $display("[TB] FAIL reset_pslverr got %b want 0", Pslverr); end
        Preset = 1'b0;
        // Penable without a setup cycle must leave the slave idle.
        for (int i = 0; i < 4; i++) begin
            @(posedge Pclk); #1;
            tests++;
            if (Pready !== 1'b0) begin fails++; $display("[TB] FAIL idle_penable cycle %0d got %b want 0", i, Pready); end
        end
        bus_idle();
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b1, 10'h004, 32'hDEADBEEF, 4'hF, 4'd0, rd, err, waits);
        tests++;
        if (waits !== 1) begin fails++; $display("[TB] FAIL zw_write_waits got %0d want 1", waits); end
        tests++;
        if (rd !== 32'h0) begin fails++; $display("[TB] FAIL zw_write_prdata got %h want 0", rd); end
        bus_idle();
        xfer(1'b0, 10'h004, 32'h0, 4'h0, 4'd0, rd, err, waits);
        tests++;
        if (waits !== 1) begin fails++; $display("[TB] FAIL zw_read_waits got %0d want 1", waits); end
        tests++;
        if (rd !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL zw_read_data got %h want deadbeef", rd); end
        bus_idle();
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b1, 10'h010, 32'h12345678, 4'hF, 4'd0, rd, err, waits);
        bus_idle();
        @(posedge Pclk); #1;
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 10'h010;
        Pwdata = 32'hFFFFFFFF; Pstrb = 4'hF; Wait_cfg = 4'd5;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        // SETUP cycle, then two ACCESS wait cycles.
        repeat (3) begin @(posedge Pclk); #1; end
        Preset = 1'b1;
        #1;
        tests++;
        if (Pready !== 1'b0) begin fails++; $display("[TB] FAIL midrst_pready got %b want 0", Pready); end
        tests++;
        if (Prdata !== 32'h0) begin fails++; $display("[TB] FAIL midrst_prdata got %h want 0", Prdata); end
        @(posedge Pclk); #1;
        Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
        Preset = 1'b0;
        xfer(1'b0, 10'h010, 32'h0, 4'h0, 4'd0, rd, err, waits);
        tests++;
        if (rd !== 32'h12345678) begin fails++; $display("[TB] FAIL midrst_word got %h want 12345678", rd); end
        bus_idle();
    endtask

    task automatic test_wait_change();
        int cnt;
        @(posedge Pclk); #1;
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = 10'h004; Wait_cfg = 4'd3;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        @(posedge Pclk); #1;
        Wait_cfg = 4'd0;
        cnt = 0;
        while (!Pready && cnt < 64) begin
            cnt++;
            @(posedge Pclk); #1;
        end
        tests++;
        if (cnt !== 3) begin fails++; $display("[TB] FAIL wait_change_cycles got %0d want 3", cnt); end
        tests++;
        if (Prdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL wait_change_data got %h want deadbeef", Prdata); end
        bus_idle();
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b1, 10'h008, 32'h11223344, 4'hF, 4'd0, rd, err, waits);
        bus_idle();
        xfer(1'b1, 10'h008, 32'hAABBCCDD, 4'b0101, 4'd2, rd, err, waits);
        tests++;
        if (waits !== 3) begin fails++; $display("[TB] FAIL strb_write_waits got %0d want 3", waits); end
        bus_idle();
        xfer(1'b0, 10'h008, 32'h0, 4'h0, 4'd0, rd, err, waits);
        tests++;
        if (rd !== 32'h11BB33DD) begin fails++; $display("[TB] FAIL strb_merge got %h want 11bb33dd", rd); end
        bus_idle();
        xfer(1'b1, 10'h008, 32'hFFFFFFFF, 4'b0000, 4'd0, rd, err, waits);
        bus_idle();
        xfer(1'b0, 10'h008, 32'h0, 4'h0, 4'd0, rd, err, waits);
        tests++;
        if (rd !== 32'h11BB33DD) begin fails++; $display("[TB] FAIL strb_zero_noop got %h want 11bb33dd", rd); end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b1, 10'h00C, 32'h0C0FFEE0, 4'hF, 4'd1, rd, err, waits);
        tests++;
        if (waits !== 2) begin fails++; $display("[TB] FAIL b2b_write_waits got %0d want 2", waits); end
        xfer(1'b0, 10'h00C, 32'h0, 4'h0, 4'd1, rd, err, waits);
        tests++;
        if (waits !== 2) begin fails++; $display("[TB] FAIL b2b_read_waits got %0d want 2", waits); end
        tests++;
        if (rd !== 32'h0C0FFEE0) begin fails++; $display("[TB] FAIL b2b_read_data got %h want 0c0ffee0", rd); end
        bus_idle();
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b1, 10'h000, 32'hCAFEF00D, 4'hF, 4'd0, rd, err, waits);
        bus_idle();
        xfer(1'b1, 10'h200, 32'h55555555, 4'hF, 4'd1, rd, err, waits);
        tests++;
        if (waits !== 2) begin fails++; $display("[TB] FAIL oor_write_waits got %0d want 2", waits); end
        tests++;
        if (err !== ERR_EN) begin fails++; $display("[TB] FAIL oor_write_slverr got %b want %b", err, ERR_EN); end
        bus_idle();
        xfer(1'b0, 10'h200, 32'h0, 4'h0, 4'd1, rd, err, waits);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("[TB] FAIL oor_read_data got %h want 0", rd); end
        tests++;
        if (err !== ERR_EN) begin fails++; $display("[TB] FAIL oor_read_slverr got %b want %b", err, ERR_EN); end
        bus_idle();
        xfer(1'b1, 10'h1FC, 32'h0BADCAFE, 4'hF, 4'd0, rd, err, waits);
        bus_idle();
        xfer(1'b0, 10'h1FC, 32'h0, 4'h0, 4'd0, rd, err, waits);
        tests++;
        if (rd !== 32'h0BADCAFE) begin fails++; $display("[TB] FAIL last_word_data got %h want 0badcafe", rd); end
        tests++;
        if (err !== 1'b0) begin fails++; $display("[TB] FAIL last_word_slverr got %b want 0", err); end
        bus_idle();
        xfer(1'b0, 10'h000, 32'h0, 4'h0, 4'd0, rd, err, waits);
        tests++;
        if (rd !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL oor_alias_word0 got %h want cafef00d", rd); end
        bus_idle();
    endtask

    task automatic test_psel_drop();
        logic [31:0] rd; logic err; int waits;
        xfer(1'b1, 10'h014, 32'hA5A5A5A5, 4'hF, 4'd0, rd, err, waits);
        bus_idle();
        @(posedge Pclk); #1;
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 10'h014;
        Pwdata = 32'h5A5A5A5A; Pstrb = 4'hF; Wait_cfg = 4'd4;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        @(posedge Pclk); #1;
        Psel = 1'b0; Penable = 1'b0;
        @(posedge Pclk); #1;
        tests++;
        if (Pready !== 1'b0) begin fails++; $display("[TB] FAIL drop_pready got %b want 0", Pready); end
        xfer(1'b0, 10'h014, 32'h0, 4'h0, 4'd0, rd, err, waits);
        tests++;
        if (rd !== 32'hA5A5A5A5) begin fails++; $display("[TB] FAIL drop_word got %h want a5a5a5a5", rd); end
        bus_idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_zero_wait();
        test_reset_mid_access();
        test_wait_change();
        test_byte_strobe();
        test_back_to_back();
        test_out_of_range();
        test_psel_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
